spart_tx: RTL
=============

SPART_TX -- requirements
Module: spart_tx

Interface
REQ-001 SHALL have parameter TICKS_PER_BIT, default 16: tx_enable pulses per serial bit.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame (8N1 framing).
REQ-003 SHALL have port clk, input, 1: single clock; all state on posedge clk.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port tx_enable, input, 1: one-clk-wide baud-rate tick at TICKS_PER_BIT x baud.
REQ-006 SHALL have port write, input, 1: load tx_in into the holding register.
REQ-007 SHALL have port tx_in, input, 8: byte to transmit.
REQ-008 SHALL have port tbr, output, 1: transmit buffer ready; holding register empty.
REQ-009 SHALL have port tx_busy, output, 1: a frame is on the line (state != IDLE).
REQ-010 SHALL have port tx_ovr, output, 1: sticky overrun; write seen while tbr=0.
REQ-011 SHALL have port txd, output, 1: registered serial line, idle high.

Function
REQ-012 SHALL be double-buffered: an 8-bit holding register plus an 8-bit shift register.
REQ-013 SHALL accept write only when tbr=1, capturing tx_in at that edge; tbr SHALL be 0 from the next cycle.
REQ-014 SHALL ignore write when tbr=0: holding register unchanged, tx_ovr set to 1 next cycle and held until rst.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 SHALL, in IDLE with the holding register full, copy holding to shift register, go to START, drive txd=0, clear the tick and bit counters, all at the same edge.
REQ-017 SHALL set tbr=1 on the cycle after that transfer; a new write can be accepted from then on, during the current frame.
REQ-018 SHALL count tx_enable pulses in a counter of width clog2(TICKS_PER_BIT); each bit is held for exactly TICKS_PER_BIT pulses, counted from the state-entry edge.
REQ-019 SHALL, on the TICKS_PER_BIT-th pulse in START, go to DATA with txd = shift[0].
REQ-020 SHALL, in DATA on the TICKS_PER_BIT-th pulse, shift right (LSB first) and increment the bit counter; after DATA_BITS bits, go to STOP with txd=1.
REQ-021 SHALL, on the TICKS_PER_BIT-th pulse in STOP, go to IDLE, or go directly to START if the holding register is full (back-to-back frames, no idle gap).
REQ-022 SHALL leave the counters and txd unchanged in cycles where tx_enable=0.
REQ-023 SHALL accept a write in the same cycle as a STOP->START transfer only if tbr=1 at that edge; the transfer reads the old holding contents.
REQ-024 SHALL drive tx_busy=1 in START, DATA and STOP, and 0 in IDLE.

Reset
REQ-025 SHALL, when rst=1 at a clk edge, force state=IDLE, txd=1, tbr=1, tx_busy=0, tx_ovr=0, clear counters and holding valid; this takes priority over write and tx_enable.
REQ-026 SHALL, on reset mid-frame, abort the frame: txd=1 on the next cycle and no partial remainder.

Structure
REQ-027 SHALL import from shared package spart_pkg: the FSM state typedef (IDLE/START/DATA/STOP), TICKS_PER_BIT default, DATA_BITS, and the START_BIT=0 / STOP_BIT=1 constants.
REQ-028 SHALL be one module with no sub-modules; the baud tick comes from the SPART baud generator, which is outside this block.

Verification
REQ-029 SHALL cover: rst, then write 0xA5 with tx_enable every 4 clk -> txd = 0,1,0,1,0,0,1,0,1,1, each for 16 ticks (64 clk); tbr low 1 cycle then high; tx_busy high for 160 ticks.
REQ-030 SHALL cover: write 0x55, then write 0x0F as soon as tbr=1 -> two contiguous frames, stop bit of frame 1 directly followed by the start bit of frame 2, no idle high gap beyond the stop bit.
REQ-031 SHALL cover: write 0x11, write 0x22 (accepted), write 0x33 while tbr=0 -> tx_ovr=1 sticky; only 0x11 and 0x22 are transmitted.
REQ-032 SHALL cover: assert rst during data bit 3 of 0xFF -> next cycle txd=1, tbr=1, tx_busy=0; a following write of 0x3C is transmitted correctly.
REQ-033 SHALL cover: tx_enable held low for 100 clk mid-bit -> txd and state are frozen; bit length resumes at the remaining tick count.
REQ-034 SHALL cover: loopback of txd into the SPART receiver, bytes 0x00, 0xFF, 0x80, 0x01 -> the receiver's rx_out matches each byte with rda asserted and no framing error.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared SPART definitions: transmitter FSM states, framing defaults and line levels.
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int TICKS_PER_BIT_DEF = 16;
    localparam int DATA_BITS_DEF     = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/spart_tx.sv
// SPART transmitter: double-buffered 8N1 serializer clocked by an external baud tick.
// A holding register decouples the host from the shift register so frames can run back to back.
module spart_tx
    import spart_pkg::*;
#(
    parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF,
    parameter int DATA_BITS     = DATA_BITS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_enable,
    input  logic       write,
    input  logic [7:0] tx_in,
    output logic       tbr,
    output logic       tx_busy,
    output logic       tx_ovr,
    output logic       txd
);

    localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_BITS - 1);

    state_t        state, state_d;
    logic [7:0]    hold_q, shift_q, shift_d;
    logic          hold_vld, ovr_q, txd_q, txd_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          tick_last, load, accept;

    assign tick_last = tx_enable && (tick_q == TICK_MAX);
    // Holding register drains into the shifter from IDLE or at the very end of a stop bit.
    assign load      = hold_vld && ((state == IDLE) || ((state == STOP) && tick_last));
    assign accept    = write && !hold_vld;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (hold_vld) state_d = START;
            START: if (tick_last) state_d = DATA;
            DATA:  if (tick_last && (bit_q == BIT_MAX)) state_d = STOP;
            STOP:  if (tick_last) state_d = hold_vld ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        txd_d   = txd_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        if (tx_enable && (state != IDLE))
            tick_d = tick_last ? '0 : tick_q + 1'b1;
        case (state)
            START: if (tick_last) txd_d = shift_q[0];
            DATA: begin
                if (tick_last) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    txd_d   = (bit_q == BIT_MAX) ? STOP_BIT : shift_q[1];
                end
            end
            STOP:  if (tick_last) txd_d = STOP_BIT;
            default: ;
        endcase
        // Tick count restarts at the edge that starts the frame, not at the next pulse.
        if (load) begin
            shift_d = hold_q;
            txd_d   = START_BIT;
            tick_d  = '0;
            bit_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txd_q    <= STOP_BIT;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            hold_q   <= '0;
            hold_vld <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            txd_q   <= txd_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            if (accept) begin
                hold_q   <= tx_in;
                hold_vld <= 1'b1;
            end else if (load) begin
                hold_vld <= 1'b0;
            end
            if (write && hold_vld) ovr_q <= 1'b1;
        end
    end

    assign tbr     = !hold_vld;
    assign tx_busy = (state != IDLE);
    assign tx_ovr  = ovr_q;
    assign txd     = txd_q;

endmodule
